// File: rtl/multi_operand_accumulator.sv
// multi_operand_accumulator
//   Sums N_IN unsigned W-bit operands per input beat and accumulates beats
//   over a frame. A frame ends on in_last or after MAX_BEATS beats, whichever
//   comes first. The frame total is then held on a valid/ready output.
//
//   Optional build macro: MULTI_OPERAND_ACCUMULATOR_SAT_EN
//     defined   : the accumulator saturates at 2^OUT_W-1 for the rest of the frame
//     undefined : the accumulator wraps modulo 2^OUT_W
//   In both builds out_ovf reports that a carry out of OUT_W occurred.
//
//   Handshakes: a transfer happens on a rising edge where valid & ready are
//   both high. in_ready is high only in ACCUM and never while rst is high.
//   out_valid stays high with stable out_* fields until out_ready is seen.
//   HOLD never accepts a beat, so there is a one-cycle bubble after each
//   frame is taken.
module multi_operand_accumulator #(
  parameter int N_IN      = 5,
  parameter int W         = 4,
  parameter int OUT_W     = 16,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_IN*W-1:0]   in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_sum,
  output logic [CNT_W-1:0]    out_beats,
  output logic                out_ovf
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             state;
  logic [OUT_W-1:0]   acc;
  logic [CNT_W-1:0]   beats;
  logic               ovf;

  logic [OUT_W-1:0]   beat_sum;
  logic [OUT_W:0]     acc_wide;
  logic [OUT_W-1:0]   acc_nxt;
  logic               carry;
  logic [CNT_W-1:0]   beats_nxt;
  logic               term;
  logic               accept;

  // Sum of all operands in the current beat, zero-extended to OUT_W.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      beat_sum = beat_sum + OUT_W'(in_data[i*W +: W]);
    end
  end

  // Next accumulator value, carry detection and frame-termination decision.
  always_comb begin
    acc_wide  = {1'b0, acc} + {1'b0, beat_sum};
    carry     = acc_wide[OUT_W];
`ifdef MULTI_OPERAND_ACCUMULATOR_SAT_EN
    // Once pinned at all-ones, any further nonzero beat carries again, so the
    // value stays saturated until the frame is released.
    acc_nxt   = carry ? {OUT_W{1'b1}} : acc_wide[OUT_W-1:0];
`else
    acc_nxt   = acc_wide[OUT_W-1:0];
`endif
    beats_nxt = beats + CNT_W'(1);
    term      = in_last || (beats_nxt == CNT_W'(MAX_BEATS));
    in_ready  = (state == ACCUM) && !rst;
    accept    = in_valid && in_ready;
  end

  // Frame FSM: accumulate beats in ACCUM, present the registered total in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      beats     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_beats <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc   <= acc_nxt;
            beats <= beats_nxt;
            ovf   <= ovf | carry;
            if (term) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_sum   <= acc_nxt;
              out_beats <= beats_nxt;
              out_ovf   <= ovf | carry;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            acc       <= '0;
            beats     <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_operand_accumulator.sv
// Directed testbench for multi_operand_accumulator.
// A default-parameter instance covers the main frame behaviour; a second
// instance with OUT_W=8 covers the overflow / saturation path.
module tb_multi_operand_accumulator;

  localparam int N_IN = 5;
  localparam int W    = 4;
  localparam int CNT_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Default instance signals
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [N_IN*W-1:0]  in_data = '0;
  logic               in_last = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [15:0]        out_sum;
  logic [CNT_W-1:0]   out_beats;
  logic               out_ovf;

  // OUT_W=8 instance signals
  logic               in_valid8 = 1'b0;
  logic               in_ready8;
  logic [N_IN*W-1:0]  in_data8 = '0;
  logic               in_last8 = 1'b0;
  logic               out_valid8;
  logic               out_ready8 = 1'b0;
  logic [7:0]         out_sum8;
  logic [CNT_W-1:0]   out_beats8;
  logic               out_ovf8;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [N_IN*W-1:0] ALL_F   = 20'hFFFFF;
  localparam logic [N_IN*W-1:0] ALL_1   = 20'h11111;
  localparam logic [N_IN*W-1:0] ASCEND  = 20'h54321; // operands 1,2,3,4,5

  // Clock
  always #5 clk = ~clk;

  multi_operand_accumulator #(
    .N_IN(N_IN), .W(W), .OUT_W(16), .MAX_BEATS(16), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_beats(out_beats), .out_ovf(out_ovf)
  );

  multi_operand_accumulator #(
    .N_IN(N_IN), .W(W), .OUT_W(8), .MAX_BEATS(16), .CNT_W(CNT_W)
  ) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_last(in_last8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_sum(out_sum8), .out_beats(out_beats8), .out_ovf(out_ovf8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat to the default instance and wait (bounded) for acceptance.
  task automatic send(input logic [N_IN*W-1:0] d, input logic last);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1;
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send8(input logic [N_IN*W-1:0] d, input logic last);
    bit done = 0;
    in_valid8 = 1'b1;
    in_data8  = d;
    in_last8  = last;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready8) done = 1;
      step();
    end
    in_valid8 = 1'b0;
    in_last8  = 1'b0;
    if (!done) check("send8_timeout", 32'd0, 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("consume_valid_low", 32'(out_valid), 32'd0);
  endtask

  task automatic consume8();
    out_ready8 = 1'b1;
    step();
    out_ready8 = 1'b0;
    check("consume8_valid_low", 32'(out_valid8), 32'd0);
  endtask

  initial begin
    // ---- Reset state
    rst = 1'b1;
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_beats", 32'(out_beats), 32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // ---- 1: single beat all-F with in_last -> 75
    send(ALL_F, 1'b1);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_sum",   32'(out_sum),   32'd75);
    check("t1_beats", 32'(out_beats), 32'd1);
    check("t1_ovf",   32'(out_ovf),   32'd0);
    check("t1_in_ready", 32'(in_ready), 32'd0);
    consume();

    // ---- 2: three beats of 1..5 with a 2-cycle gap after the first -> 45
    send(ASCEND, 1'b0);
    check("t2_valid_mid", 32'(out_valid), 32'd0);
    in_data = ALL_F; in_last = 1'b1;  // ignored while in_valid is low
    step();
    step();
    check("t2_gap_valid", 32'(out_valid), 32'd0);
    send(ASCEND, 1'b0);
    send(ASCEND, 1'b1);
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_sum",   32'(out_sum),   32'd45);
    check("t2_beats", 32'(out_beats), 32'd3);
    consume();

    // ---- 3: 16 beats of all-F, no in_last -> forced end 1200
    for (int b = 0; b < 15; b++) send(ALL_F, 1'b0);
    check("t3_valid_at15", 32'(out_valid), 32'd0);
    send(ALL_F, 1'b0);
    check("t3_valid", 32'(out_valid), 32'd1);
    check("t3_sum",   32'(out_sum),   32'd1200);
    check("t3_beats", 32'(out_beats), 32'd16);
    check("t3_ovf",   32'(out_ovf),   32'd0);
    check("t3_in_ready", 32'(in_ready), 32'd0);

    // ---- 4: stall in HOLD for 5 cycles with in_valid high
    in_valid = 1'b1; in_data = ALL_1; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("t4_hold_valid",    32'(out_valid), 32'd1);
      check("t4_hold_sum",      32'(out_sum),   32'd1200);
      check("t4_hold_in_ready", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t4_release_valid",    32'(out_valid), 32'd0);
    check("t4_release_in_ready", 32'(in_ready),  32'd1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    check("t4_next_valid", 32'(out_valid), 32'd1);
    check("t4_next_sum",   32'(out_sum),   32'd5);
    check("t4_next_beats", 32'(out_beats), 32'd1);
    consume();

    // ---- in_last on the MAX_BEATS-th beat: exactly one frame
    for (int b = 0; b < 15; b++) send(ALL_1, 1'b0);
    send(ALL_1, 1'b1);
    check("lastmax_valid", 32'(out_valid), 32'd1);
    check("lastmax_sum",   32'(out_sum),   32'd80);
    check("lastmax_beats", 32'(out_beats), 32'd16);
    consume();
    step();
    step();
    check("lastmax_no_extra", 32'(out_valid), 32'd0);

    // ---- 6: reset mid-frame, then a clean 1-beat frame
    send(ALL_F, 1'b0);
    send(ALL_F, 1'b0);
    rst = 1'b1;
    step();
    check("t6_rst_valid",    32'(out_valid), 32'd0);
    check("t6_rst_sum",      32'(out_sum),   32'd0);
    check("t6_rst_in_ready", 32'(in_ready),  32'd0);
    rst = 1'b0;
    #1;
    send(ALL_1, 1'b1);
    check("t6_valid", 32'(out_valid), 32'd1);
    check("t6_sum",   32'(out_sum),   32'd5);
    check("t6_beats", 32'(out_beats), 32'd1);
    check("t6_ovf",   32'(out_ovf),   32'd0);
    consume();

    // ---- 5: OUT_W=8, 4 beats of all-F (true total 300)
    for (int b = 0; b < 3; b++) send8(ALL_F, 1'b0);
    send8(ALL_F, 1'b1);
    check("t5_valid", 32'(out_valid8), 32'd1);
`ifdef MULTI_OPERAND_ACCUMULATOR_SAT_EN
    check("t5_sum",   32'(out_sum8),   32'd255);
`else
    check("t5_sum",   32'(out_sum8),   32'd44);
`endif
    check("t5_ovf",   32'(out_ovf8),   32'd1);
    check("t5_beats", 32'(out_beats8), 32'd4);
    consume8();
    send8(ALL_1, 1'b1);
    check("t5_clean_sum", 32'(out_sum8), 32'd5);
    check("t5_clean_ovf", 32'(out_ovf8), 32'd0);
    consume8();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
